// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: request size encoding and FSM states.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// Little-endian lane logic: extracts and extends sub-word load data, and merges
// sub-word store data into a full word for read-modify-write.
module load_store_align
  import mem_access_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] word,
  input  logic [1:0]   addr_lo,
  input  logic [1:0]   size,
  input  logic         sign_ext,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] load_data,
  output logic [n-1:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  size_t       size_e;

  always_comb begin
    size_e = size_t'(size);
    byte_v = word[7:0];
    case (addr_lo)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size_e)
      SZ_BYTE: load_data = {{(n-8){sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: load_data = {{(n-16){sign_ext & half_v[15]}}, half_v};
      default: load_data = word;
    endcase

    store_word = word;
    case (size_e)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-addressed data memory: one request in flight,
// sub-word stores by read-modify-write, alignment and range errors reported in one cycle.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_write_enable,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_writedata,
  input  logic [n-1:0] mem_readdata
);

  state_t       state_q, state_d;
  logic         write_q, write_d;
  logic [1:0]   size_q, size_d;
  logic         signed_q, signed_d;
  logic [n-1:0] addr_q, addr_d;
  logic [n-1:0] wdata_q, wdata_d;
  logic [n-1:0] word_q, word_d;
  logic [n-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic         req_err;
  logic         accept;
  logic [n-1:0] align_word;
  logic [n-1:0] load_ext;
  logic [n-1:0] store_merge;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    case (size_t'(req_size))
      SZ_HALF:    req_err = req_addr[0];
      SZ_WORD:    req_err = |req_addr[1:0];
      SZ_ILLEGAL: req_err = 1'b1;
      default:    req_err = 1'b0;
    endcase
    if ({2'b00, req_addr[n-1:2]} >= n'(DEPTH)) req_err = 1'b1;
  end

  // During RD the lane logic sees live memory data for load extraction;
  // during WR it sees the captured word for the store merge.
  assign align_word = (state_q == RD) ? mem_readdata : word_q;

  load_store_align #(.n(n)) u_align (
    .word       (align_word),
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_ext),
    .store_word (store_merge)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          word_d   = '0;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)                                  state_d = RESP;
          else if (req_write && (size_t'(req_size) == SZ_WORD)) state_d = WR;
          else                                          state_d = RD;
        end
      end
      RD: begin
        word_d = mem_readdata;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  // Enable is gated by rst_n so a reset landing in WR never commits the write.
  assign mem_write_enable = rst_n && (state_q == WR);
  assign mem_addr         = ((state_q == RD) || (state_q == WR)) ? {addr_q[n-1:2], 2'b00} : '0;
  assign mem_writedata    = (state_q != WR) ? '0 :
                            (size_t'(size_q) == SZ_WORD) ? wdata_q : store_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural memory, scoreboard of expected responses
// with their due cycle, and one task per scenario.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_enable;
  logic [31:0] mem_addr, mem_writedata, mem_readdata;

  mem_access_unit #(.n(32), .DEPTH(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  int          we_count = 0;
  logic [31:0] last_we_addr = '0;
  int          cyc = 0;

  assign mem_readdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) begin
      mem[mem_addr[7:2]] <= mem_writedata;
      we_count           <= we_count + 1;
      last_we_addr       <= mem_addr;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;
  int last_accept = 0;

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (resp_rdata !== e.rd) begin
          fails++;
          $display("FAIL resp_rdata: got %h, want %h", resp_rdata, e.rd);
        end
        checks++;
        if (resp_err !== e.err) begin
          fails++;
          $display("FAIL resp_err: got %b, want %b", resp_err, e.err);
        end
        checks++;
        if (cyc !== e.due) begin
          fails++;
          $display("FAIL resp_latency: got cycle %0d, want cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic backdoor(input int idx, input logic [31:0] d);
    bd_idx  = idx[5:0];
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input logic keep);
    int waited;
    exp_t e;
    waited     = 0;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    e.rd  = exp_rd;
    e.err = exp_err;
    e.due = cyc + lat;
    sb.push_back(e);
    last_accept = cyc;
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n_wait;
    n_wait = 0;
    while (sb.size() != 0 && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    if (sb.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_in_reset: got %b, want 0", req_ready); end
    checks++;
    if (mem_write_enable !== 1'b0) begin fails++; $display("FAIL we_in_reset: got %b, want 0", mem_write_enable); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b, want 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL resp_after_reset: got v=%b e=%b d=%h, want 0 0 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_writedata !== 32'h0) begin
      fails++;
      $display("FAIL mem_bus_idle: got addr=%h wd=%h, want 0 0", mem_addr, mem_writedata);
    end
  endtask

  task automatic test_word();
    int we0;
    we0 = we_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    drain();
    checks++;
    if (we_count - we0 !== 1) begin fails++; $display("FAIL word_store_we_count: got %0d, want 1", we_count - we0); end
    checks++;
    if (last_we_addr !== 32'h10) begin fails++; $display("FAIL word_store_addr: got %h, want 00000010", last_we_addr); end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL word_store_mem: got %h, want deadbeef", mem[4]); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
    drain();
  endtask

  task automatic test_byte_store();
    int we0;
    backdoor(4, 32'h11223344);
    we0 = we_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h0, 1'b0, 3, 1'b0);
    drain();
    checks++;
    if (mem[4] !== 32'h1122AB44) begin fails++; $display("FAIL byte_store_mem: got %h, want 1122ab44", mem[4]); end
    checks++;
    if (we_count - we0 !== 1) begin fails++; $display("FAIL byte_store_we_count: got %0d, want 1", we_count - we0); end
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF5566, 32'h0, 1'b0, 3, 1'b0);
    drain();
    checks++;
    if (mem[4] !== 32'h5566AB44) begin fails++; $display("FAIL half_store_mem: got %h, want 5566ab44", mem[4]); end
  endtask

  task automatic test_loads();
    backdoor(4, 32'h1122AB44);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000AB, 1'b0, 2, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h00000044, 1'b0, 2, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001122, 1'b0, 2, 1'b0);
    drain();
    backdoor(4, 32'h80010000);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0);
    drain();
  endtask

  task automatic test_errors();
    int we0;
    we0 = we_count;
    do_req(1'b0, 2'b01, 1'b1, 32'h13,  32'h0,        32'h0, 1'b1, 1, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h02,  32'h12345678, 32'h0, 1'b1, 1, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0, 1'b1, 1, 1'b0);
    do_req(1'b1, 2'b11, 1'b0, 32'h10,  32'h12345678, 32'h0, 1'b1, 1, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0, 1'b1, 1, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000005A, 32'h0, 1'b1, 1, 1'b0);
    drain();
    checks++;
    if (we_count - we0 !== 0) begin fails++; $display("FAIL error_we_count: got %0d, want 0", we_count - we0); end
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'hCAFE0000, 1'b0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, a3;
    backdoor(63, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1'b1);
    a0 = last_accept;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1'b1);
    a1 = last_accept;
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000003C, 32'h0, 1'b0, 3, 1'b1);
    a2 = last_accept;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA5A53CA5, 1'b0, 2, 1'b0);
    a3 = last_accept;
    drain();
    checks++;
    if (a1 - a0 !== 3) begin fails++; $display("FAIL b2b_gap_word_store: got %0d, want 3", a1 - a0); end
    checks++;
    if (a2 - a1 !== 3) begin fails++; $display("FAIL b2b_gap_load: got %0d, want 3", a2 - a1); end
    checks++;
    if (a3 - a2 !== 4) begin fails++; $display("FAIL b2b_gap_byte_store: got %0d, want 4", a3 - a2); end
  endtask

  task automatic test_reset_mid_write();
    int we0;
    backdoor(8, 32'hCAFEF00D);
    @(negedge clk);
    we0 = we_count;
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h00000077; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready_pre: got %b, want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b1) begin fails++; $display("FAIL rst_mid_in_wr: got we=%b, want 1", mem_write_enable); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_gating: got we=%b ready=%b, want 0 0", mem_write_enable, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_recover: got ready=%b resp_valid=%b, want 1 0", req_ready, resp_valid);
    end
    checks++;
    if (mem[8] !== 32'hCAFEF00D) begin fails++; $display("FAIL rst_mid_mem: got %h, want cafef00d", mem[8]); end
    checks++;
    if (we_count - we0 !== 0) begin fails++; $display("FAIL rst_mid_we_count: got %0d, want 0", we_count - we0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[63] = 32'hCAFE0000;
    test_reset();
    test_word();
    test_byte_store();
    test_loads();
    test_errors();
    drain();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded, want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
